// File: rtl/gauss_blur_3x3.sv
// 3x3 Gaussian blur on a three-row pixel stream (RGB888 plus sop/eop), fixed 3-cycle latency.
// Border pixels and bypass mode pass the centre RGB through unchanged.
module gauss_blur_3x3 #(
    parameter int LINE_WIDTH   = 640,
    parameter int FRAME_HEIGHT = 480,
    parameter int DATA_WIDTH   = 26
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] row_top,
    input  logic [DATA_WIDTH-1:0] row_mid,
    input  logic [DATA_WIDTH-1:0] row_bot,
    input  logic                  in_valid,
    input  logic                  filter_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid
);

    localparam int CW = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int RW = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(LINE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);

    // Weighted row sum a + 2b + c for one 8-bit channel (max 1020).
    function automatic logic [9:0] row_sum(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
        return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
    endfunction

    // Combine row sums with weights 1/2/1 and round; 4080 + 8 still fits in 12 bits.
    function automatic logic [7:0] kernel_round(input logic [9:0] t, input logic [9:0] m,
                                                input logic [9:0] b);
        logic [11:0] sum;
        sum = {2'b00, t} + {1'b0, m, 1'b0} + {2'b00, b} + 12'd8;
        return sum[11:4];
    endfunction

    logic [23:0]           win_top_r [3];
    logic [DATA_WIDTH-1:0] win_mid_r [3];
    logic [23:0]           win_bot_r [3];
    logic [9:0]            part_r    [3][3];
    logic [DATA_WIDTH-1:0] ctr_r;
    logic [2:0]            vld_r;
    logic [2:0]            bdr_r;
    logic [CW-1:0]         col_r;
    logic [RW-1:0]         row_r;
    logic [DATA_WIDTH-1:0] out_r;
    logic                  out_valid_r;

    logic [CW-1:0]         pos_col_s;
    logic [RW-1:0]         pos_row_s;
    logic [CW-1:0]         col_nxt_s;
    logic [RW-1:0]         row_nxt_s;
    logic                  border_s;
    logic [7:0]            blur_s [3];
    logic [DATA_WIDTH-1:0] out_nxt_s;
    logic                  unused_s;

    assign unused_s = ^{row_top[1:0], row_bot[1:0], win_mid_r[0][1:0], win_mid_r[2][1:0]};

    // Position of the incoming centre pixel and the position expected after it.
    always_comb begin
        pos_col_s = col_r;
        pos_row_s = row_r;
        if (in_valid && row_mid[1]) begin
            pos_col_s = '0;
            pos_row_s = '0;
        end else begin
            pos_col_s = col_r;
            pos_row_s = row_r;
        end
        if (pos_col_s == COL_LAST) begin
            col_nxt_s = '0;
            row_nxt_s = (pos_row_s == ROW_LAST) ? pos_row_s : pos_row_s + RW'(1);
        end else begin
            col_nxt_s = pos_col_s + CW'(1);
            row_nxt_s = pos_row_s;
        end
        border_s = (pos_col_s == '0) || (pos_col_s == COL_LAST) ||
                   (pos_row_s == '0) || (pos_row_s == ROW_LAST);
    end

    // Position counters advance only on valid centre pixels.
    always_ff @(posedge clk) begin
        if (!rst) begin
            col_r <= '0;
            row_r <= '0;
        end else if (in_valid) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Window shift plus valid/border pipes (edges k and k+1).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                win_top_r[i] <= '0;
                win_mid_r[i] <= '0;
                win_bot_r[i] <= '0;
            end
            vld_r <= 3'b000;
            bdr_r <= 3'b000;
        end else begin
            win_top_r[0] <= row_top[2 +: 24];
            win_mid_r[0] <= row_mid;
            win_bot_r[0] <= row_bot[2 +: 24];
            for (int i = 1; i < 3; i++) begin
                win_top_r[i] <= win_top_r[i-1];
                win_mid_r[i] <= win_mid_r[i-1];
                win_bot_r[i] <= win_bot_r[i-1];
            end
            vld_r <= {vld_r[1:0], in_valid};
            bdr_r <= {bdr_r[1:0], border_s};
        end
    end

    // Per-row weighted partial sums and the delayed centre word (edge k+2).
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int r = 0; r < 3; r++) begin
                for (int ch = 0; ch < 3; ch++) begin
                    part_r[r][ch] <= '0;
                end
            end
            ctr_r <= '0;
        end else begin
            for (int ch = 0; ch < 3; ch++) begin
                part_r[0][ch] <= row_sum(win_top_r[2][8*ch +: 8], win_top_r[1][8*ch +: 8],
                                         win_top_r[0][8*ch +: 8]);
                part_r[1][ch] <= row_sum(win_mid_r[2][2+8*ch +: 8], win_mid_r[1][2+8*ch +: 8],
                                         win_mid_r[0][2+8*ch +: 8]);
                part_r[2][ch] <= row_sum(win_bot_r[2][8*ch +: 8], win_bot_r[1][8*ch +: 8],
                                         win_bot_r[0][8*ch +: 8]);
            end
            ctr_r <= win_mid_r[1];
        end
    end

    // Final sum, rounding and the border/bypass select.
    always_comb begin
        out_nxt_s = ctr_r;
        for (int ch = 0; ch < 3; ch++) begin
            blur_s[ch] = kernel_round(part_r[0][ch], part_r[1][ch], part_r[2][ch]);
        end
        if (filter_en && !bdr_r[2]) begin
            for (int ch = 0; ch < 3; ch++) begin
                out_nxt_s[2+8*ch +: 8] = blur_s[ch];
            end
        end else begin
            out_nxt_s = ctr_r;
        end
    end

    // Output register (edge k+3).
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_r       <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_r       <= out_nxt_s;
            out_valid_r <= vld_r[2];
        end
    end

    assign data_out  = rst ? out_r : '0;
    assign out_valid = rst & out_valid_r;

endmodule

// File: tb/tb_gauss_blur_3x3.sv
// Directed bench for gauss_blur_3x3 on a small frame: image-level reference model,
// per-cycle output comparison, and hand-computed literal checks.
module tb_gauss_blur_3x3;

    localparam int LW = 12;
    localparam int FH = 10;
    localparam int DW = 26;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] row_top = '0;
    logic [DW-1:0] row_mid = '0;
    logic [DW-1:0] row_bot = '0;
    logic          in_valid = 1'b0;
    logic          filter_en = 1'b0;
    logic [DW-1:0] data_out;
    logic          out_valid;

    gauss_blur_3x3 #(.LINE_WIDTH(LW), .FRAME_HEIGHT(FH), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .row_top(row_top), .row_mid(row_mid), .row_bot(row_bot),
        .in_valid(in_valid), .filter_en(filter_en), .data_out(data_out), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [23:0]   img [FH][LW];
    logic [23:0]   got [FH*LW];
    int            got_idx = 0;
    logic          frame_fen = 1'b1;
    logic          cur_v = 1'b0;
    logic [DW-1:0] cur_d = '0;
    logic [3:0]    mv = 4'b0000;
    logic [DW-1:0] md [4];

    // Reference output for the centre pixel at (r,c) of the current image.
    function automatic logic [DW-1:0] exp_word(int r, int c, logic fen);
        logic [23:0] rgb;
        int s;
        rgb = img[r][c];
        if (fen && r > 0 && r < FH-1 && c > 0 && c < LW-1) begin
            for (int ch = 0; ch < 3; ch++) begin
                s = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        s += ((dr == 0) ? 2 : 1) * ((dc == 0) ? 2 : 1) *
                             int'(img[r+dr][c+dc][8*ch +: 8]);
                rgb[8*ch +: 8] = 8'((s + 8) / 16);
            end
        end
        return {rgb, (r == 0 && c == 0), (c == LW-1)};
    endfunction

    // Model latency: an expectation enters at the sampling edge and is due three edges later.
    always @(posedge clk) begin
        if (!rst) begin
            mv <= 4'b0000;
            for (int i = 0; i < 4; i++) md[i] <= '0;
        end else begin
            mv <= {mv[2:0], cur_v};
            md[0] <= cur_d;
            for (int i = 1; i < 4; i++) md[i] <= md[i-1];
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        checks++;
        if (!rst) begin
            if (data_out !== '0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset_out: got data=%h valid=%b, want 0/0", data_out, out_valid);
            end
        end else begin
            if (out_valid !== mv[3]) begin
                errors++;
                $display("FAIL out_valid @%0t: got %b, want %b", $time, out_valid, mv[3]);
            end
            if (mv[3]) begin
                checks++;
                if (data_out !== md[3]) begin
                    errors++;
                    $display("FAIL data_out @%0t: got %h, want %h", $time, data_out, md[3]);
                end
            end
            if (out_valid === 1'b1) begin
                if (data_out[1]) got_idx = 0;
                if (got_idx < FH*LW) got[got_idx] = data_out[25:2];
                got_idx++;
            end
        end
    end

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [DW-1:0] t, input logic [DW-1:0] m,
                        input logic [DW-1:0] b, input logic [DW-1:0] e);
        @(posedge clk);
        #1;
        in_valid  = v;
        row_top   = t;
        row_mid   = m;
        row_bot   = b;
        filter_en = frame_fen;
        cur_v     = v;
        cur_d     = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0);
    endtask

    // Stream one frame (optionally stopping early at pixel index abort_at).
    task automatic run_frame(input int abort_at);
        int r, c;
        logic [DW-1:0] t, m, b;
        for (int idx = 0; idx < FH*LW; idx++) begin
            if (idx == abort_at) break;
            r = idx / LW;
            c = idx % LW;
            m = {img[r][c], (r == 0 && c == 0), (c == LW-1)};
            t = (r > 0) ? {img[r-1][c], 2'b00} : '0;
            b = (r < FH-1) ? {img[r+1][c], 2'b00} : '0;
            step(1'b1, t, m, b, exp_word(r, c, frame_fen));
        end
        if (abort_at < 0) idle(6);
    endtask

    task automatic fill(input logic [23:0] v);
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++) img[r][c] = v;
    endtask

    task automatic fill_random();
        for (int r = 0; r < FH; r++)
            for (int c = 0; c < LW; c++) img[r][c] = 24'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) md[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // Uniform mid-grey frame, blur on.
        frame_fen = 1'b1;
        fill(24'h808080);
        run_frame(-1);
        chk("uniform_interior", got[3*LW+4], 24'h808080);
        chk("uniform_corner", got[0], 24'h808080);

        // Red impulse at (5,5).
        fill(24'h000000);
        img[5][5] = 24'hFF0000;
        run_frame(-1);
        chk("impulse_centre", got[5*LW+5], 24'h400000);
        chk("impulse_left", got[5*LW+4], 24'h200000);
        chk("impulse_right", got[5*LW+6], 24'h200000);
        chk("impulse_up", got[4*LW+5], 24'h200000);
        chk("impulse_down", got[6*LW+5], 24'h200000);
        chk("impulse_diag_ul", got[4*LW+4], 24'h100000);
        chk("impulse_diag_dr", got[6*LW+6], 24'h100000);
        chk("impulse_far", got[5*LW+8], 24'h000000);

        // Saturated white: full-scale sum must not wrap.
        fill(24'hFFFFFF);
        run_frame(-1);
        chk("white_interior", got[4*LW+4], 24'hFFFFFF);

        // Random frame, blur on: borders pass through.
        fill_random();
        run_frame(-1);
        chk("random_border_tl", got[0], img[0][0]);
        chk("random_border_br", got[FH*LW-1], img[FH-1][LW-1]);

        // Random frame, bypass.
        frame_fen = 1'b0;
        fill_random();
        run_frame(-1);
        chk("bypass_interior", got[2*LW+3], img[2][3]);

        // Mid-line reset, then a clean frame.
        frame_fen = 1'b1;
        fill_random();
        run_frame(3*LW+5);
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; cur_v = 1'b0; cur_d = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(4);
        run_frame(-1);
        chk("post_reset_interior", got[4*LW+4], exp_word(4, 4, 1'b1) >> 2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
